// File: rtl/entropy_collector_pkg.sv
// fpga_entropy_defs: register map, CTRL/STATUS bit positions and address decode helpers
// shared by the entropy collector and its users.
package fpga_entropy_defs;

    localparam logic [7:0] ENT_ADDR_PREFIX = 8'h10;

    localparam logic [7:0] ADDR_NAME0    = 8'h00;
    localparam logic [7:0] ADDR_NAME1    = 8'h01;
    localparam logic [7:0] ADDR_VERSION  = 8'h02;
    localparam logic [7:0] ADDR_CTRL     = 8'h08;
    localparam logic [7:0] ADDR_STATUS   = 8'h09;
    localparam logic [7:0] ADDR_DATA     = 8'h10;
    localparam logic [7:0] ADDR_OVERFLOW = 8'h11;

    localparam int CTRL_ENABLE_BIT      = 0;
    localparam int CTRL_FLUSH_BIT       = 1;
    localparam int STATUS_NOT_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT      = 1;
    localparam int STATUS_COUNT_LSB     = 8;
    localparam int STATUS_BITCNT_LSB    = 16;

    function automatic logic addr_is_mapped(input logic [7:0] a);
        return a inside {ADDR_NAME0, ADDR_NAME1, ADDR_VERSION, ADDR_CTRL,
                         ADDR_STATUS, ADDR_DATA, ADDR_OVERFLOW};
    endfunction

    function automatic logic addr_is_ro(input logic [7:0] a);
        return a inside {ADDR_NAME0, ADDR_NAME1, ADDR_VERSION, ADDR_STATUS, ADDR_DATA};
    endfunction

endpackage

// File: rtl/entropy_collector_fifo.sv
// entropy_fifo: synchronous FIFO with combinational head; a write while full is accepted
// only when a read happens in the same cycle.
module entropy_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_wr, do_rd;

    assign empty_o   = count_q == '0;
    assign full_o    = count_q == (DEPTH_LOG2+1)'(DEPTH);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = clear_i ? '0 : do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = clear_i ? '0 : do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = clear_i ? '0 : count_q + (DEPTH_LOG2+1)'(do_wr) - (DEPTH_LOG2+1)'(do_rd);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && !clear_i && do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/entropy_collector.sv
// entropy_collector: packs single-bit noise samples into 32-bit words, queues them in a FIFO
// and exposes control, status and data registers on the cs/we/address core bus.
module entropy_collector
    import fpga_entropy_defs::*;
#(
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [31:0] CORE_NAME0      = 32'h656e7463,
    parameter logic [31:0] CORE_NAME1      = 32'h6f6c6c20,
    parameter logic [31:0] CORE_VERSION    = 32'h302e3130
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        noise_bit_i,
    input  logic        noise_valid_i,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic [7:0]  address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        error_o,
    output logic [7:0]  debug_o
);

    localparam int CW = FIFO_DEPTH_LOG2 + 1;

    logic        enable_q, enable_d;
    logic [31:0] word_q, word_d, overflow_q, overflow_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  debug_q, debug_d;
    logic [31:0] fifo_head, new_word, status, rd_mux;
    logic        fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic        ctrl_wr, ovf_wr, flush, sample, complete, push, pop, drop, err, unused_wdata;

    assign unused_wdata = ^write_data_i[31:2];

    assign ctrl_wr  = cs_i && we_i && address_i == ADDR_CTRL;
    assign ovf_wr   = cs_i && we_i && address_i == ADDR_OVERFLOW;
    assign flush    = ctrl_wr && write_data_i[CTRL_FLUSH_BIT];
    assign sample   = enable_q && noise_valid_i;
    assign complete = sample && bitcnt_q == 5'd31;
    assign new_word = {word_q[30:0], noise_bit_i};
    assign push     = complete && !flush;
    assign pop      = reset_n_i && cs_i && !we_i && address_i == ADDR_DATA && !fifo_empty;
    assign drop     = push && fifo_full && !pop;

    entropy_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (flush),
        .wr_en_i   (push),
        .wr_data_i (new_word),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    always_comb begin
        enable_d   = ctrl_wr ? write_data_i[CTRL_ENABLE_BIT] : enable_q;
        word_d     = flush ? '0 : sample ? new_word : word_q;
        bitcnt_d   = flush ? '0 : sample ? bitcnt_q + 5'd1 : bitcnt_q;
        overflow_d = ovf_wr ? '0 : (drop && overflow_q != '1) ? overflow_q + 32'd1 : overflow_q;
        debug_d    = complete ? new_word[31:24] : debug_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            enable_q   <= 1'b0;
            word_q     <= '0;
            bitcnt_q   <= '0;
            overflow_q <= '0;
            debug_q    <= '0;
        end else begin
            enable_q   <= enable_d;
            word_q     <= word_d;
            bitcnt_q   <= bitcnt_d;
            overflow_q <= overflow_d;
            debug_q    <= debug_d;
        end
    end

    always_comb begin
        status                                = '0;
        status[STATUS_NOT_EMPTY_BIT]          = !fifo_empty;
        status[STATUS_FULL_BIT]               = fifo_full;
        status[STATUS_COUNT_LSB +: CW]        = fifo_count;
        status[STATUS_BITCNT_LSB +: 5]        = bitcnt_q;
    end

    always_comb begin
        rd_mux = '0;
        case (address_i)
            ADDR_NAME0:    rd_mux = CORE_NAME0;
            ADDR_NAME1:    rd_mux = CORE_NAME1;
            ADDR_VERSION:  rd_mux = CORE_VERSION;
            ADDR_CTRL:     rd_mux[CTRL_ENABLE_BIT] = enable_q;
            ADDR_STATUS:   rd_mux = status;
            ADDR_DATA:     rd_mux = fifo_head;
            ADDR_OVERFLOW: rd_mux = overflow_q;
            default:       rd_mux = '0;
        endcase
    end

    // An empty DATA read is an error and must not leak a stale FIFO slot.
    assign err = !addr_is_mapped(address_i) || (we_i && addr_is_ro(address_i))
               || (!we_i && address_i == ADDR_DATA && fifo_empty);
    assign error_o     = cs_i && err;
    assign read_data_o = (cs_i && !we_i && !err) ? rd_mux : '0;
    assign debug_o     = debug_q;

endmodule

// File: tb/tb_entropy_collector.sv
// tb_entropy_collector: scoreboard bench; expected words are queued as noise is fed and
// compared when the host pops DATA.
module tb_entropy_collector;

    logic        clk = 1'b0, reset_n = 1'b0, noise_bit = 1'b0, noise_valid = 1'b0;
    logic        cs = 1'b0, we = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        error;
    logic [7:0]  debug;

    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_q [$];
    logic        menable = 1'b0;
    logic [4:0]  mbit = '0;
    logic [31:0] mword = '0, movf = '0;
    logic [7:0]  mdbg = '0;

    always #5 clk = ~clk;

    entropy_collector dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .noise_bit_i   (noise_bit),
        .noise_valid_i (noise_valid),
        .cs_i          (cs),
        .we_i          (we),
        .address_i     (address),
        .write_data_i  (write_data),
        .read_data_o   (read_data),
        .error_o       (error),
        .debug_o       (debug)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] status_exp();
        int n = exp_q.size();
        return {11'd0, mbit, 3'd0, 5'(n), 6'd0, n == 16, n != 0};
    endfunction

    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
        @(negedge clk);
        cs = 1'b1; we = w; address = a; write_data = d;
        #1;
        rd = read_data; er = error;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] r; logic e;
        access(1'b0, a, 32'd0, r, e);
        chk(tag, r, exp);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] r; logic e;
        access(1'b1, a, d, r, e);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() != 0) rd_chk(tag, 8'h10, exp_q.pop_front(), 1'b0);
        else rd_chk(tag, 8'h10, 32'd0, 1'b1);
    endtask

    task automatic model_bit(input logic b);
        if (menable) begin
            mword = {mword[30:0], b};
            mbit  = mbit + 5'd1;
            if (mbit == 5'd0) begin
                mdbg = mword[31:24];
                if (exp_q.size() < 16) exp_q.push_back(mword);
                else if (movf != 32'hffffffff) movf = movf + 32'd1;
            end
        end
    endtask

    // Optionally reads DATA in the same cycle as the sample, so pop precedes any push.
    task automatic feed_bit(input logic b, input logic do_pop);
        @(negedge clk);
        noise_valid = 1'b1; noise_bit = b;
        if (do_pop) begin cs = 1'b1; we = 1'b0; address = 8'h10; end
        #1;
        if (do_pop) begin
            if (exp_q.size() != 0) begin
                chk("pp_data", read_data, exp_q.pop_front());
                chk("pp_err", {31'd0, error}, 32'd0);
            end else begin
                chk("pp_data", read_data, 32'd0);
                chk("pp_err", {31'd0, error}, 32'd1);
            end
        end
        @(posedge clk); #1;
        noise_valid = 1'b0; cs = 1'b0;
        model_bit(b);
    endtask

    task automatic feed_word(input logic [31:0] w, input logic pop_last);
        for (int i = 31; i >= 0; i--) feed_bit(w[i], pop_last && i == 0);
    endtask

    task automatic set_ctrl(input logic [31:0] d);
        wr_chk("ctrl_wr", 8'h08, d, 1'b0);
        menable = d[0];
        if (d[1]) begin exp_q.delete(); mbit = '0; mword = '0; end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_rdata", read_data, 32'd0);
        chk("idle_err", {31'd0, error}, 32'd0);
        chk("rst_debug", {24'd0, debug}, 32'd0);
        rd_chk("rst_status", 8'h09, 32'h0, 1'b0);
        rd_chk("name0", 8'h00, 32'h656e7463, 1'b0);
        rd_chk("name1", 8'h01, 32'h6f6c6c20, 1'b0);
        rd_chk("version", 8'h02, 32'h302e3130, 1'b0);
        rd_chk("rst_ovf", 8'h11, 32'h0, 1'b0);

        // packing
        set_ctrl(32'd1);
        rd_chk("ctrl_rd", 8'h08, 32'd1, 1'b0);
        feed_word(32'hdeadbeef, 1'b0);
        rd_chk("pack_status", 8'h09, status_exp(), 1'b0);
        chk("pack_status_const", status_exp(), 32'h0000_0101);
        chk("pack_debug", {24'd0, debug}, 32'h0000_00de);
        pop_chk("pack_data");
        rd_chk("pack_status2", 8'h09, status_exp(), 1'b0);

        // overflow
        for (int k = 0; k < 17; k++) feed_word($urandom, 1'b0);
        rd_chk("ovf_status", 8'h09, 32'h0000_1003, 1'b0);
        rd_chk("ovf_count", 8'h11, movf, 1'b0);
        chk("ovf_debug", {24'd0, debug}, {24'd0, mdbg});
        for (int k = 0; k < 16; k++) pop_chk("ovf_drain");
        pop_chk("empty_data");
        wr_chk("ovf_clr", 8'h11, 32'h1234, 1'b0);
        movf = '0;
        rd_chk("ovf_cleared", 8'h11, 32'h0, 1'b0);

        // full push+pop
        for (int k = 0; k < 16; k++) feed_word($urandom, 1'b0);
        feed_word(32'hcafef00d, 1'b1);
        rd_chk("pp_status", 8'h09, 32'h0000_1003, 1'b0);
        rd_chk("pp_ovf", 8'h11, 32'h0, 1'b0);
        chk("pp_tail", exp_q[15], 32'hcafef00d);
        for (int k = 0; k < 16; k++) pop_chk("pp_drain");

        // errors
        rd_chk("unmapped", 8'h55, 32'h0, 1'b1);
        wr_chk("ro_write", 8'h00, 32'hffffffff, 1'b1);
        wr_chk("status_write", 8'h09, 32'hffffffff, 1'b1);
        rd_chk("name0_kept", 8'h00, 32'h656e7463, 1'b0);

        // partial word, then flush
        feed_word(32'h89abcdef, 1'b0);
        for (int k = 0; k < 10; k++) feed_bit(k[0], 1'b0);
        set_ctrl(32'd0);
        for (int k = 0; k < 3; k++) feed_bit(1'b1, 1'b0);
        rd_chk("part_status", 8'h09, status_exp(), 1'b0);
        chk("part_status_const", status_exp(), 32'h000a_0101);
        set_ctrl(32'd3);
        rd_chk("flush_status", 8'h09, 32'h0, 1'b0);
        rd_chk("flush_ctrl", 8'h08, 32'd1, 1'b0);

        // disabling CTRL write coincident with a sample: old enable still applies
        @(negedge clk);
        cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'd0;
        noise_valid = 1'b1; noise_bit = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0; noise_valid = 1'b0;
        model_bit(1'b1);
        menable = 1'b0;
        rd_chk("late_en_status", 8'h09, 32'h0001_0000, 1'b0);
        rd_chk("late_en_ctrl", 8'h08, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
